mv_dot_scheduler: RTL and testbench
===================================

Name: mv_dot_scheduler

Overview:
Sequences a 16-lane FP32 dot-product datapath (multiplier row plus 4-level adder tree, fixed latency, no stall input) for matrix-vector jobs.
- Accepts a job descriptor (rows × chunks), issues paired matrix/vector beats and tags each beat.
- Re-associates datapath results with {row, chunk, last} through a latency-matched tag line.
- Buffers results in an output FIFO; credit gating guarantees no result is ever dropped.

Parameters:
NUM, 16, lanes per beat
DW, 32, element width (FP32)
DP_LATENCY, 20, datapath cycles from dp_valid to valid dp_result (≥1)
ROW_W, 16, row counter width
CHUNK_W, 8, chunk counter width
OUT_DEPTH, 32, output FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  high only in IDLE
cfg_rows  in  ROW_W  rows in job
cfg_chunks  in  CHUNK_W  16-element chunks per row
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted
in_mat  in  DW*NUM  matrix chunk
in_vec  in  DW*NUM  vector chunk
dp_valid  out  1  issue strobe to datapath
dp_mat  out  DW*NUM  to datapath
dp_vec  out  DW*NUM  to datapath
dp_result  in  DW  datapath sum
out_valid  out  1  result available
out_ready  in  1  consumer accept
out_data  out  DW  partial dot product
out_row  out  ROW_W  row index
out_chunk  out  CHUNK_W  chunk index
out_last  out  1  last chunk of row
busy  out  1  state != IDLE
done  out  1  one-cycle job-complete pulse
perf_stall_cycles  out  32  credit-stall count (see feature)

Behaviour:
- Clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, all counters 0, tag line cleared, FIFO empty. in_ready, dp_valid, out_valid, busy and done are 0; out_* data are 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on cfg_valid&cfg_ready. Rows and chunks are latched; row_cnt and chunk_cnt cleared.
  - If cfg_rows==0 or cfg_chunks==0, IDLE→DONE directly and nothing is issued.
  - RUN→DRAIN in the cycle the final beat issues (row_cnt==rows-1, chunk_cnt==chunks-1).
  - DRAIN→DONE when inflight==0 and the FIFO is empty.
  - DONE→IDLE unconditionally; done=1 only in DONE.
- Issue: issue = in_valid & in_ready. in_ready = (state==RUN) & (inflight + fifo_count < OUT_DEPTH).
  - dp_valid = issue. dp_mat/dp_vec are combinational pass-throughs of in_mat/in_vec.
  - Operands are don't-care when dp_valid=0.
- Counters: chunk_cnt increments per issue and wraps to 0 at chunks-1, at which point row_cnt increments. Tag last = (chunk_cnt==chunks-1).
- Tag line: a DP_LATENCY-stage shift register of {valid, row, chunk, last}, loaded with issue and the current counters.
  - The stage-DP_LATENCY output is aligned with dp_result. When its valid bit is set, {dp_result, tag} is pushed into the FIFO in that same cycle.
- inflight: number of valid tags in the line. It is +1 on issue, -1 on retire, and unchanged when both happen in the same cycle.
- Credit invariant: inflight + fifo_count ≤ OUT_DEPTH at all times, so a FIFO push always has space. A push into a full FIFO is a design error; bench asserts it never occurs.
- FIFO: first-word fall-through. out_valid = !empty; pop on out_valid&out_ready. Simultaneous push and pop at full or empty is legal and leaves the count unchanged.
- Total latency from issue to out_valid: DP_LATENCY+1 cycles (FIFO write, then visible).
- Reset mid-job: all state is discarded immediately, including in-flight tags. Datapath results emerging after reset are ignored because the tag valids are 0.
- cfg_* is ignored outside IDLE.

Optional Feature:
- Macro MV_SCHED_PERF_EN.
- When defined: perf_stall_cycles increments (saturating at 2^32-1) each cycle with state==RUN, in_valid=1 and in_ready=0. It clears on rst and on job acceptance.
- When undefined: perf_stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Job rows=2, chunks=3, in_valid always high, out_ready always high → 6 issues in 6 consecutive cycles. Outputs arrive in order with (row,chunk,last) = (0,0,0),(0,1,0),(0,2,1),(1,0,0),(1,1,0),(1,2,1). First out_valid is DP_LATENCY+1 cycles after the first issue; done pulses once, one cycle after the FIFO empties.
- out_ready=0 with OUT_DEPTH=32 and a job of rows=40, chunks=1 → exactly 32 issues, then in_ready=0. Raising out_ready resumes issue; all 40 results are delivered and none are lost.
- cfg_rows=0 → DONE the cycle after acceptance, no dp_valid, done=1 for 1 cycle, back to IDLE.
- rst asserted 5 cycles into a rows=4, chunks=4 job → next cycle: IDLE, out_valid=0, busy=0. A new job after that outputs only its own tags.
- Same-cycle issue, retire and pop with the FIFO at OUT_DEPTH-1 → count and inflight stay stable and in_ready remains consistent with the credit equation.
- With MV_SCHED_PERF_EN, out_ready held 0 for 50 cycles after the credit limit → perf_stall_cycles=50. Without the macro it reads 0.

Source files
------------

// File: rtl/mv_dot_scheduler.sv
// Matrix-vector job scheduler for a fixed-latency 16-lane FP32 dot-product datapath.
// Optional stall-cycle performance counter is built only when MV_SCHED_PERF_EN is defined.
module mv_dot_scheduler #(
    parameter int NUM        = 16,
    parameter int DW         = 32,
    parameter int DP_LATENCY = 20,
    parameter int ROW_W      = 16,
    parameter int CHUNK_W    = 8,
    parameter int OUT_DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ROW_W-1:0]     cfg_rows,
    input  logic [CHUNK_W-1:0]   cfg_chunks,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW*NUM-1:0]    in_mat,
    input  logic [DW*NUM-1:0]    in_vec,
    output logic                 dp_valid,
    output logic [DW*NUM-1:0]    dp_mat,
    output logic [DW*NUM-1:0]    dp_vec,
    input  logic [DW-1:0]        dp_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [ROW_W-1:0]     out_row,
    output logic [CHUNK_W-1:0]   out_chunk,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          perf_stall_cycles
);

    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = PTR_W + 2;
    localparam int ENT_W = DW + ROW_W + CHUNK_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    logic [ROW_W-1:0]     rows_q;
    logic [ROW_W-1:0]     row_cnt_q;
    logic [CHUNK_W-1:0]   chunks_q;
    logic [CHUNK_W-1:0]   chunk_cnt_q;

    logic [DP_LATENCY-1:0] tag_v_q;
    logic [ROW_W-1:0]      tag_row_q   [DP_LATENCY];
    logic [CHUNK_W-1:0]    tag_chunk_q [DP_LATENCY];
    logic [DP_LATENCY-1:0] tag_last_q;
    logic [CRD_W-1:0]      inflight_q;

    logic [ENT_W-1:0]     fifo_mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     fifo_cnt_q;

    logic issue_s;
    logic retire_s;
    logic pop_s;
    logic fifo_empty_s;
    logic credit_ok_s;
    logic last_chunk_s;
    logic last_row_s;

    // A result slot is reserved at issue time, so a retiring tag always finds FIFO space.
    assign credit_ok_s  = (inflight_q + CRD_W'(fifo_cnt_q)) < CRD_W'(OUT_DEPTH);
    assign fifo_empty_s = (fifo_cnt_q == CNT_W'(0));
    assign last_chunk_s = (chunk_cnt_q == (chunks_q - CHUNK_W'(1)));
    assign last_row_s   = (row_cnt_q == (rows_q - ROW_W'(1)));

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_RUN) && credit_ok_s;
    assign issue_s   = in_valid && in_ready;
    assign dp_valid  = issue_s;
    assign dp_mat    = in_mat;
    assign dp_vec    = in_vec;
    assign retire_s  = tag_v_q[DP_LATENCY-1];
    assign out_valid = !fifo_empty_s;
    assign pop_s     = out_valid && out_ready;

    // Job FSM with row/chunk issue counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rows_q      <= '0;
            chunks_q    <= '0;
            row_cnt_q   <= '0;
            chunk_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        rows_q      <= cfg_rows;
                        chunks_q    <= cfg_chunks;
                        row_cnt_q   <= '0;
                        chunk_cnt_q <= '0;
                        if ((cfg_rows == ROW_W'(0)) || (cfg_chunks == CHUNK_W'(0))) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        if (last_chunk_s) begin
                            chunk_cnt_q <= '0;
                            row_cnt_q   <= row_cnt_q + ROW_W'(1);
                            if (last_row_s) begin
                                state_q <= ST_DRAIN;
                            end
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + CHUNK_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_q == CRD_W'(0)) && fifo_empty_s) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag line matched to the datapath latency; its last stage lines up with dp_result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q    <= '0;
            tag_last_q <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                tag_row_q[i]   <= '0;
                tag_chunk_q[i] <= '0;
            end
        end else begin
            for (int i = DP_LATENCY - 1; i > 0; i--) begin
                tag_v_q[i]     <= tag_v_q[i-1];
                tag_row_q[i]   <= tag_row_q[i-1];
                tag_chunk_q[i] <= tag_chunk_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
            end
            tag_v_q[0]     <= issue_s;
            tag_row_q[0]   <= row_cnt_q;
            tag_chunk_q[0] <= chunk_cnt_q;
            tag_last_q[0]  <= last_chunk_s;
        end
    end

    // Count of valid tags currently travelling through the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            case ({issue_s, retire_s})
                2'b10:   inflight_q <= inflight_q + CRD_W'(1);
                2'b01:   inflight_q <= inflight_q - CRD_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (retire_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({retire_s, pop_s})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are only ever observed through valid pointers.
    always_ff @(posedge clk) begin
        if (retire_s) begin
            fifo_mem_q[wr_ptr_q] <= {dp_result, tag_row_q[DP_LATENCY-1],
                                     tag_chunk_q[DP_LATENCY-1], tag_last_q[DP_LATENCY-1]};
        end
    end

    // First-word fall-through head; data reads as zero while empty.
    always_comb begin
        out_data  = '0;
        out_row   = '0;
        out_chunk = '0;
        out_last  = 1'b0;
        if (!fifo_empty_s) begin
            {out_data, out_row, out_chunk, out_last} = fifo_mem_q[rd_ptr_q];
        end else begin
            out_data  = '0;
            out_row   = '0;
            out_chunk = '0;
            out_last  = 1'b0;
        end
    end

`ifdef MV_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of cycles where a ready beat was held back by credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else if ((state_q == ST_IDLE) && cfg_valid) begin
            perf_q <= 32'd0;
        end else if ((state_q == ST_RUN) && in_valid && !in_ready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mv_dot_scheduler.sv
// Bench for mv_dot_scheduler: transaction-level job model, stub datapath, per-cycle compare.
module tb_mv_dot_scheduler;

    localparam int NUM = 16, DW = 32, L = 20, ROW_W = 16, CHUNK_W = 8, DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [ROW_W-1:0]     cfg_rows = '0;
    logic [CHUNK_W-1:0]   cfg_chunks = '0;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW*NUM-1:0]    in_mat;
    logic [DW*NUM-1:0]    in_vec;
    logic                 dp_valid;
    logic [DW*NUM-1:0]    dp_mat;
    logic [DW*NUM-1:0]    dp_vec;
    logic [DW-1:0]        dp_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [ROW_W-1:0]     out_row;
    logic [CHUNK_W-1:0]   out_chunk;
    logic                 out_last;
    logic                 busy;
    logic                 done;
    logic [31:0]          perf_stall_cycles;

    mv_dot_scheduler #(.NUM(NUM), .DW(DW), .DP_LATENCY(L), .ROW_W(ROW_W),
                       .CHUNK_W(CHUNK_W), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_rows(cfg_rows), .cfg_chunks(cfg_chunks), .in_valid(in_valid),
        .in_ready(in_ready), .in_mat(in_mat), .in_vec(in_vec), .dp_valid(dp_valid),
        .dp_mat(dp_mat), .dp_vec(dp_vec), .dp_result(dp_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_chunk(out_chunk), .out_last(out_last), .busy(busy), .done(done),
        .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    // Stand-in datapath: lane-wise xor, summed, delayed by L cycles.
    function automatic logic [31:0] dp_fn(input logic [DW*NUM-1:0] m, input logic [DW*NUM-1:0] v);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < NUM; i++) s = s + (m[i*DW +: DW] ^ v[i*DW +: DW]);
        return s;
    endfunction

    logic [DW-1:0] pipe [L];
    initial for (int i = 0; i < L; i++) pipe[i] = 32'd0;
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= dp_valid ? dp_fn(dp_mat, dp_vec) : (32'hBAD0_0000 ^ $urandom());
    end
    assign dp_result = pipe[L-1];

    // Scoreboard and bookkeeping
    typedef struct { logic [31:0] data; int row; int chunk; bit last; longint t; } exp_t;
    exp_t   q[$];
    int     n_cmp = 0, n_bad = 0;
    bit     chk_en = 1'b0;
    int     phase = 0, tot = 0, n_iss = 0, n_pop = 0, m_chunks = 1;
    longint cyc = 0, done_cyc = -1;
    logic [31:0] m_perf = 32'd0;
    int     obs_dp_cnt = 0, obs_done_cnt = 0;
    longint first_iss = -1, last_iss = -1, first_ov = -1;
    int     pop_row[$], pop_chunk[$];
    bit     pop_last[$];
    int     iv_mode = 0, or_mode = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        bit e_run, e_ir, e_dv, e_ov;
        e_run = (phase == 1) && (n_iss < tot);
        e_ir  = e_run && ((n_iss - n_pop) < DEPTH);
        e_dv  = e_ir && in_valid;
        e_ov  = (q.size() > 0) && (cyc >= q[0].t + L + 1);
        check("cfg_ready", 64'(cfg_ready), 64'(phase == 0));
        check("in_ready", 64'(in_ready), 64'(e_ir));
        check("dp_valid", 64'(dp_valid), 64'(e_dv));
        check("out_valid", 64'(out_valid), 64'(e_ov));
        check("busy", 64'(busy), 64'(phase == 1));
        check("done", 64'(done), 64'((phase == 1) && (cyc == done_cyc)));
        check("perf", 64'(perf_stall_cycles), 64'(m_perf));
        if (e_ov && out_valid) begin
            check("out_data", 64'(out_data), 64'(q[0].data));
            check("out_row", 64'(out_row), 64'(q[0].row));
            check("out_chunk", 64'(out_chunk), 64'(q[0].chunk));
            check("out_last", 64'(out_last), 64'(q[0].last));
        end
        if (dp_valid) begin
            obs_dp_cnt++;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
        end
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (done) obs_done_cnt++;
        if (rst) begin
            q.delete();
            phase = 0; tot = 0; n_iss = 0; n_pop = 0; done_cyc = -1; m_perf = 32'd0;
        end else if (phase == 0) begin
            if (cfg_valid) begin
                tot = int'(cfg_rows) * int'(cfg_chunks);
                m_chunks = (cfg_chunks == 0) ? 1 : int'(cfg_chunks);
                n_iss = 0; n_pop = 0; phase = 1; m_perf = 32'd0;
                done_cyc = (tot == 0) ? cyc + 1 : -1;
            end
        end else begin
`ifdef MV_SCHED_PERF_EN
            if (e_run && in_valid && !e_ir && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
`endif
            if (e_dv) begin
                exp_t e;
                e.data  = dp_fn(in_mat, in_vec);
                e.row   = n_iss / m_chunks;
                e.chunk = n_iss % m_chunks;
                e.last  = (e.chunk == m_chunks - 1);
                e.t     = cyc;
                q.push_back(e);
                n_iss++;
            end
            if (e_ov && out_ready) begin
                if (out_valid) begin
                    pop_row.push_back(int'(out_row));
                    pop_chunk.push_back(int'(out_chunk));
                    pop_last.push_back(out_last);
                end
                void'(q.pop_front());
                n_pop++;
                if (n_pop == tot) done_cyc = cyc + 2;
            end
            if (cyc == done_cyc) phase = 0;
        end
    endtask

    // Compare process: one model step per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) model_cycle();
        end
    end

    // Input driver
    initial begin
        in_valid = 1'b0; out_ready = 1'b0; in_mat = '0; in_vec = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM; i++) begin
                in_mat[i*DW +: DW] = $urandom();
                in_vec[i*DW +: DW] = $urandom();
            end
            case (iv_mode)
                0: in_valid = 1'b0;
                1: in_valid = 1'b1;
                default: in_valid = ($urandom_range(3) != 0);
            endcase
            case (or_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(9) < 3);
            endcase
        end
    end

    task automatic clear_obs();
        obs_dp_cnt = 0; obs_done_cnt = 0; first_iss = -1; last_iss = -1; first_ov = -1;
        pop_row.delete(); pop_chunk.delete(); pop_last.delete();
    endtask

    task automatic start_job(input int r, input int c);
        @(posedge clk); #1;
        cfg_rows = ROW_W'(r); cfg_chunks = CHUNK_W'(c); cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k;
        bit seen;
        k = 0; seen = 1'b0;
        while (!seen && k < budget) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            k++;
        end
        check(nm, 64'(seen), 64'd1);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_r[6];
        int exp_c[6];
        bit exp_l[6];
        int k;
        exp_r = '{0, 0, 0, 1, 1, 1};
        exp_c = '{0, 1, 2, 0, 1, 2};
        exp_l = '{0, 0, 1, 0, 0, 1};

        // Reset
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);

        // Job 2x3, free-flowing
        iv_mode = 1; or_mode = 1;
        clear_obs();
        start_job(2, 3);
        wait_done(200, "job23_done");
        check("job23_issues", 64'(obs_dp_cnt), 64'd6);
        check("job23_issue_span", 64'(last_iss - first_iss), 64'd5);
        check("job23_latency", 64'(first_ov - first_iss), 64'(L + 1));
        check("job23_done_cnt", 64'(obs_done_cnt), 64'd1);
        check("job23_pops", 64'(pop_row.size()), 64'd6);
        for (int i = 0; i < 6 && i < pop_row.size(); i++) begin
            check("job23_row", 64'(pop_row[i]), 64'(exp_r[i]));
            check("job23_chunk", 64'(pop_chunk[i]), 64'(exp_c[i]));
            check("job23_last", 64'(pop_last[i]), 64'(exp_l[i]));
        end

        // Credit limit: 40x1 with consumer stalled
        iv_mode = 1; or_mode = 0;
        clear_obs();
        start_job(40, 1);
        k = 0;
        @(negedge clk);
        while (in_ready && k < 100) begin @(negedge clk); k++; end
        check("credit_stop", 64'(in_ready), 64'd0);
        repeat (50) @(negedge clk);
        check("credit_issues", 64'(obs_dp_cnt), 64'(DEPTH));
`ifdef MV_SCHED_PERF_EN
        check("perf_50", 64'(perf_stall_cycles), 64'd50);
`else
        check("perf_off", 64'(perf_stall_cycles), 64'd0);
`endif
        @(posedge clk);
        or_mode = 1;
        wait_done(600, "job40_done");
        check("job40_pops", 64'(pop_row.size()), 64'd40);
        check("job40_issues", 64'(obs_dp_cnt), 64'd40);

        // Empty jobs
        clear_obs();
        start_job(0, 5);
        wait_done(10, "rows0_done");
        start_job(3, 0);
        wait_done(10, "chunks0_done");
        check("empty_no_issue", 64'(obs_dp_cnt), 64'd0);
        check("empty_done_cnt", 64'(obs_done_cnt), 64'd2);

        // Reset in the middle of a 4x4 job, then a short job
        iv_mode = 1; or_mode = 1;
        start_job(4, 4);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_cfg_ready", 64'(cfg_ready), 64'd1);
        clear_obs();
        start_job(1, 2);
        wait_done(200, "after_rst_done");
        check("after_rst_pops", 64'(pop_row.size()), 64'd2);
        if (pop_row.size() == 2) begin
            check("after_rst_chunk1", 64'(pop_chunk[1]), 64'd1);
            check("after_rst_last1", 64'(pop_last[1]), 64'd1);
            check("after_rst_row1", 64'(pop_row[1]), 64'd0);
        end

        // Throttled job: FIFO sits near full with concurrent issue/retire/pop
        iv_mode = 2; or_mode = 2;
        clear_obs();
        start_job(6, 10);
        wait_done(3000, "throttle_done");
        check("throttle_pops", 64'(pop_row.size()), 64'd60);

        iv_mode = 0; or_mode = 0;
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
